// File: rtl/oh_clkgate_ctrl.sv
// Idle-detect clock-gate controller.
// Produces clk_en for a latch-based clock-gating cell: it gates the downstream
// clock after idle_count consecutive idle samples and restores it on busy or
// on a four-phase wake_req/wake_ack handshake, holding a fixed settle window
// of WAKE_CYCLES cycles before the domain is considered running again.
// Runs on the free-running clk; every output is a flop, so clk_en only moves
// on the rising edge and is stable while the gating latch is transparent.
//
// Ports:
//   clk         free-running clock (never the gated clock)
//   reset       synchronous active-high reset
//   idle_count  consecutive idle samples before gating; 0 disables gating
//   busy        activity from the gated domain; blocks gating, triggers wake
//   wake_req    four-phase wake request from another agent
//   wake_ack    acknowledge: domain running and wake_req seen
//   clk_en      enable to the gating cell; 1 lets the clock through
//   gated       1 while the clock is gated
module oh_clkgate_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] idle_count,
  input  logic         busy,
  input  logic         wake_req,
  output logic         wake_ack,
  output logic         clk_en,
  output logic         gated
);

  localparam int unsigned WW = 8;
  localparam logic [N-1:0]  IDLE_MAX  = '1;
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]   wake_cnt_q, wake_cnt_d;
  logic            idle_c;

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    idle_c     = !busy && !wake_req;

    unique case (state_q)
      ST_RUN: begin
        if (!idle_c) begin
          idle_cnt_d = '0;
        end else if ((idle_count != '0) && (idle_cnt_q >= (idle_count - N'(1)))) begin
          // This idle sample completes the run; live threshold is used.
          state_d    = ST_OFF;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + N'(1);
        end
      end
      ST_OFF: begin
        idle_cnt_d = '0;
        if (!idle_c) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Settle window: inputs ignored, cannot fall back to OFF.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      clk_en     <= 1'b1;
      gated      <= 1'b0;
      wake_ack   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en     <= (state_d != ST_OFF);
      gated      <= (state_d == ST_OFF);
      // Ack only once the domain has been running for a full cycle, so a
      // request arriving in OFF is answered 1+WAKE_CYCLES cycles later.
      wake_ack   <= wake_req && (state_q == ST_RUN);
    end
  end

endmodule

// File: tb/tb_oh_clkgate_ctrl.sv
// Self-checking bench for oh_clkgate_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// controller's observable rules.
module tb_oh_clkgate_ctrl;

  localparam int unsigned N           = 8;
  localparam int unsigned WAKE_CYCLES = 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] idle_count;
  logic         busy;
  logic         wake_req;
  logic         wake_ack;
  logic         clk_en;
  logic         gated;

  oh_clkgate_ctrl #(.N(N), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .idle_count (idle_count),
    .busy       (busy),
    .wake_req   (wake_req),
    .wake_ack   (wake_ack),
    .clk_en     (clk_en),
    .gated      (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode plus lengths of the current idle run and of the
  // time spent waking, counted with plain integers.
  typedef enum int {M_RUN, M_OFF, M_WAKE} mode_t;
  mode_t mode      = M_RUN;
  int    idle_run  = 0;
  int    woke_for  = 0;
  logic  exp_ack   = 1'b0;

  task automatic model_edge(input logic r, input logic b, input logic w, input int ic);
    mode_t prev;
    prev = mode;
    if (r) begin
      mode = M_RUN; idle_run = 0; woke_for = 0; exp_ack = 1'b0;
    end else begin
      // Ack follows the request once the domain was already running.
      exp_ack = w && (prev == M_RUN);
      case (prev)
        M_RUN: begin
          if (b || w) idle_run = 0;
          else begin
            idle_run = idle_run + 1;
            if (ic != 0 && idle_run >= ic) begin mode = M_OFF; idle_run = 0; end
          end
        end
        M_OFF: if (b || w) begin mode = M_WAKE; woke_for = 0; end
        default: begin
          woke_for = woke_for + 1;
          if (woke_for >= int'(WAKE_CYCLES)) begin mode = M_RUN; idle_run = 0; end
        end
      endcase
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic w);
    reset = r; busy = b; wake_req = w;
    @(posedge clk);
    model_edge(r, b, w, int'(idle_count));
    #1;
    check1("clk_en",   clk_en,   mode != M_OFF);
    check1("gated",    gated,    mode == M_OFF);
    check1("wake_ack", wake_ack, exp_ack);
  endtask

  initial begin
    logic b, w;
    reset = 1'b1; busy = 1'b1; wake_req = 1'b0; idle_count = N'(3);

    // 1: reset held two cycles
    step(1, 1, 0);
    step(1, 1, 0);
    check1("reset_clk_en", clk_en, 1'b1);
    check1("reset_gated",  gated,  1'b0);

    // 2: three idle edges gate, busy wakes, settle returns to RUN
    step(0, 0, 0);
    step(0, 0, 0);
    check1("not_yet_gated", gated, 1'b0);
    step(0, 0, 0);
    check1("gated_after_3", gated, 1'b1);
    step(0, 0, 0);
    step(0, 1, 0);
    check1("busy_wakes", clk_en, 1'b1);
    step(0, 0, 0);
    step(0, 0, 0);

    // 3: interrupted idle run with threshold 4
    idle_count = N'(4);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    check1("no_gate_before_4", clk_en, 1'b1);
    step(0, 0, 0);
    check1("gate_after_8th", clk_en, 1'b0);

    // 4: wake handshake from OFF
    step(0, 0, 1);
    check1("req_wakes", clk_en, 1'b1);
    step(0, 0, 1);
    step(0, 0, 1);
    check1("ack_not_early", wake_ack, 1'b0);
    step(0, 0, 1);
    check1("ack_3_after", wake_ack, 1'b1);
    step(0, 0, 1);
    step(0, 0, 0);
    check1("ack_drops", wake_ack, 1'b0);
    repeat (4) step(0, 0, 0);
    check1("regate_req", gated, 1'b1);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // 5: gating disabled, counter saturates, then live threshold applies
    idle_count = '0;
    repeat (300) step(0, 0, 0);
    check1("disabled_no_gate", gated, 1'b0);
    idle_count = N'(5);
    step(0, 0, 0);
    check1("saturated_gates_now", gated, 1'b1);

    // 6: reset during WAKE and during OFF
    step(0, 1, 0);
    step(1, 0, 0);
    check1("rst_in_wake", clk_en, 1'b1);
    repeat (4) step(0, 0, 0);
    check1("rst_wake_full_run", gated, 1'b0);
    step(0, 0, 0);
    check1("rst_wake_regate", gated, 1'b1);
    step(1, 0, 0);
    check1("rst_in_off", gated, 1'b0);
    repeat (4) step(0, 0, 0);
    step(0, 0, 0);
    check1("rst_off_regate", gated, 1'b1);

    // Randomized traffic with held requests and occasional resets.
    w = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) idle_count = N'($urandom_range(0, 7));
      b = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) w = ~w;
      step(($urandom_range(0, 199) == 0), b, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
